// File: rtl/mem_port_initiator_if.sv
// Request/memory/response signal bundle for one memory port initiator.
// The slave modport is the initiator's view; master is the requester/memory side.
interface mem_port_initiator_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 8
);
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_we;
  logic [ADDR_W-1:0] i_req_addr;
  logic [DATA_W-1:0] i_req_wdata;
  logic              o_en;
  logic              o_we;
  logic [ADDR_W-1:0] o_addr;
  logic [DATA_W-1:0] o_wdata;
  logic [DATA_W-1:0] i_mem_dout;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [DATA_W-1:0] o_rsp_rdata;
  logic              o_busy;

  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_mem_dout, i_rsp_ready,
    output o_req_ready, o_en, o_we, o_addr, o_wdata, o_rsp_valid, o_rsp_rdata, o_busy
  );

  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_mem_dout, i_rsp_ready,
    input  o_req_ready, o_en, o_we, o_addr, o_wdata, o_rsp_valid, o_rsp_rdata, o_busy
  );
endinterface

// File: rtl/mem_port_initiator.sv
// Request-side initiator for one memory port: registers requests onto the
// port, tracks reads through the fixed read latency and returns the data in
// order through a first-word-fall-through response FIFO. Read acceptance is
// credit limited so a returning word always has a FIFO slot waiting.
module mem_port_initiator #(
  parameter int DATA_W     = 12,
  parameter int ADDR_W     = 8,
  parameter int RD_LATENCY = 1,
  parameter int RSP_DEPTH  = 4
) (
  input logic                 clka,
  input logic                 i_rst,
  mem_port_initiator_if.slave port_if
);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] fifo_q [RSP_DEPTH];

  logic [CNT_W-1:0]  credits_s;
  logic              req_ready_s;
  logic              accept_s;
  logic              rd_accept_s;
  logic              push_s;
  logic              pop_s;
  logic              rsp_valid_s;

  // Credit check, handshakes and next-state for issue, latency and FIFO state.
  always_comb begin
    credits_s   = DEPTH_C - count_q - inflight_q;
    // A write never lands in the FIFO, so it is accepted without a credit.
    req_ready_s = ~i_rst & (port_if.i_req_we | (credits_s != {CNT_W{1'b0}}));
    accept_s    = port_if.i_req_valid & req_ready_s;
    rd_accept_s = accept_s & ~port_if.i_req_we;
    push_s      = vld_q[RD_LATENCY-1];
    pop_s       = port_if.i_rsp_ready & (count_q != {CNT_W{1'b0}});

    en_d    = accept_s;
    we_d    = accept_s & port_if.i_req_we;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept_s) begin
      addr_d  = port_if.i_req_addr;
      wdata_d = port_if.i_req_wdata;
    end else begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
    end

    // Stage 0 marks the issue cycle of a read; the last stage lines up with dout.
    vld_d    = {RD_LATENCY{1'b0}};
    vld_d[0] = en_q & ~we_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    inflight_d = inflight_q + CNT_W'(rd_accept_s) - CNT_W'(push_s);
    count_d    = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push_s);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop_s);
  end

  // Control and issue registers with synchronous reset.
  always_ff @(posedge clka) begin
    if (i_rst) begin
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      vld_q      <= {RD_LATENCY{1'b0}};
      inflight_q <= {CNT_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
    end else begin
      en_q       <= en_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Response storage; contents are only meaningful between the pointers.
  always_ff @(posedge clka) begin
    if (push_s && !i_rst) begin
      fifo_q[wr_ptr_q] <= port_if.i_mem_dout;
    end
  end

  assign rsp_valid_s         = (count_q != {CNT_W{1'b0}});
  assign port_if.o_req_ready = req_ready_s;
  assign port_if.o_en        = en_q;
  assign port_if.o_we        = we_q;
  assign port_if.o_addr      = addr_q;
  assign port_if.o_wdata     = wdata_q;
  assign port_if.o_rsp_valid = rsp_valid_s;
  assign port_if.o_rsp_rdata = rsp_valid_s ? fifo_q[rd_ptr_q] : {DATA_W{1'b0}};
  assign port_if.o_busy      = (inflight_q != {CNT_W{1'b0}}) | rsp_valid_s;
endmodule

// File: tb/tb_mem_port_initiator.sv
// Directed bench: DUT A uses read latency 1, DUT B read latency 3; both share
// the same request/response stimulus and each has its own memory model.
module tb_mem_port_initiator;
  logic        clka = 1'b0;
  logic        rst;
  logic        req_valid, req_we, rsp_ready;
  logic [7:0]  req_addr;
  logic [11:0] req_wdata;
  logic [11:0] dout_a, b_s1, b_s2, b_s3;
  logic [11:0] mem_a [256];
  logic [11:0] mem_b [256];
  logic [11:0] exp_v;
  int checks = 0;
  int passes = 0;

  always #5 clka = ~clka;

  mem_port_initiator_if #(.DATA_W(12), .ADDR_W(8)) ifa ();
  mem_port_initiator_if #(.DATA_W(12), .ADDR_W(8)) ifb ();

  assign ifa.i_req_valid = req_valid;
  assign ifa.i_req_we    = req_we;
  assign ifa.i_req_addr  = req_addr;
  assign ifa.i_req_wdata = req_wdata;
  assign ifa.i_rsp_ready = rsp_ready;
  assign ifa.i_mem_dout  = dout_a;
  assign ifb.i_req_valid = req_valid;
  assign ifb.i_req_we    = req_we;
  assign ifb.i_req_addr  = req_addr;
  assign ifb.i_req_wdata = req_wdata;
  assign ifb.i_rsp_ready = rsp_ready;
  assign ifb.i_mem_dout  = b_s3;

  mem_port_initiator #(.DATA_W(12), .ADDR_W(8), .RD_LATENCY(1), .RSP_DEPTH(4)) u_a (
    .clka(clka), .i_rst(rst), .port_if(ifa));
  mem_port_initiator #(.DATA_W(12), .ADDR_W(8), .RD_LATENCY(3), .RSP_DEPTH(4)) u_b (
    .clka(clka), .i_rst(rst), .port_if(ifb));

  // Memory model, latency 1.
  always @(posedge clka) begin
    if (ifa.o_en) begin
      if (ifa.o_we) mem_a[ifa.o_addr] <= ifa.o_wdata;
      else dout_a <= mem_a[ifa.o_addr];
    end
  end

  // Memory model, latency 3.
  always @(posedge clka) begin
    if (ifb.o_en) begin
      if (ifb.o_we) mem_b[ifb.o_addr] <= ifb.o_wdata;
      else b_s1 <= mem_b[ifb.o_addr];
    end
    b_s2 <= b_s1;
    b_s3 <= b_s2;
  end

  // Invariants: no push into a full FIFO, inflight bounded by the FIFO depth.
  always @(negedge clka) begin
    if (!rst && u_a.push_s && !u_a.pop_s && u_a.count_q == 3'd4) begin
      checks++; $display("FAIL a_push_full: push with count %0d, required no push", u_a.count_q);
    end
    if (!rst && u_b.push_s && !u_b.pop_s && u_b.count_q == 3'd4) begin
      checks++; $display("FAIL b_push_full: push with count %0d, required no push", u_b.count_q);
    end
    if (!rst && u_b.inflight_q > 3'd4) begin
      checks++; $display("FAIL b_inflight: got %0d, required <= 4", u_b.inflight_q);
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task do_reset;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clka);
    rst = 1'b0;
  endtask

  task test_reset;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b1; rsp_ready = 1'b0;
    req_addr = 8'h00; req_wdata = 12'h000;
    repeat (2) @(negedge clka);
    checks++; if ({ifa.o_en, ifa.o_we, ifa.o_addr, ifa.o_wdata, ifa.o_rsp_valid, ifa.o_busy} !== 23'd0)
      $display("FAIL rst_outs_a: got %h, required 0", {ifa.o_en, ifa.o_we, ifa.o_addr, ifa.o_wdata, ifa.o_rsp_valid, ifa.o_busy}); else passes++;
    checks++; if ({ifb.o_en, ifb.o_we, ifb.o_addr, ifb.o_wdata, ifb.o_rsp_valid, ifb.o_busy} !== 23'd0)
      $display("FAIL rst_outs_b: got %h, required 0", {ifb.o_en, ifb.o_we, ifb.o_addr, ifb.o_wdata, ifb.o_rsp_valid, ifb.o_busy}); else passes++;
    checks++; if ({ifa.o_req_ready, ifb.o_req_ready} !== 2'b00)
      $display("FAIL rst_ready: got %b, required 00", {ifa.o_req_ready, ifb.o_req_ready}); else passes++;
    rst = 1'b0; req_we = 1'b0;
    @(negedge clka);
    checks++; if ({ifa.o_req_ready, ifb.o_req_ready} !== 2'b11)
      $display("FAIL rst_release_ready: got %b, required 11", {ifa.o_req_ready, ifb.o_req_ready}); else passes++;
    checks++; if (ifa.o_rsp_rdata !== 12'h000)
      $display("FAIL rst_rdata: got %h, required 000", ifa.o_rsp_rdata); else passes++;
  endtask

  task test_write_read;
    do_reset;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 12'h0A5;
    @(negedge clka);
    checks++; if ({ifa.o_en, ifa.o_we, ifa.o_addr, ifa.o_wdata} !== {1'b1, 1'b1, 8'h10, 12'h0A5})
      $display("FAIL wr_issue: got %b%b %h %h, required 11 10 0a5", ifa.o_en, ifa.o_we, ifa.o_addr, ifa.o_wdata); else passes++;
    req_we = 1'b0;
    #1;
    checks++; if (ifa.o_req_ready !== 1'b1)
      $display("FAIL rd_ready: got %b, required 1", ifa.o_req_ready); else passes++;
    @(negedge clka);
    checks++; if ({ifa.o_en, ifa.o_we, ifa.o_addr, ifa.o_rsp_valid} !== {1'b1, 1'b0, 8'h10, 1'b0})
      $display("FAIL rd_issue: got %b%b %h %b, required 10 10 0", ifa.o_en, ifa.o_we, ifa.o_addr, ifa.o_rsp_valid); else passes++;
    req_valid = 1'b0;
    @(negedge clka);
    checks++; if ({ifa.o_en, ifa.o_addr, ifa.o_rsp_valid, ifa.o_busy} !== {1'b0, 8'h10, 1'b0, 1'b1})
      $display("FAIL idle_hold: got %b %h %b %b, required 0 10 0 1", ifa.o_en, ifa.o_addr, ifa.o_rsp_valid, ifa.o_busy); else passes++;
    @(negedge clka);
    checks++; if ({ifa.o_rsp_valid, ifa.o_rsp_rdata} !== {1'b1, 12'h0A5})
      $display("FAIL raw_rsp: got %b %h, required 1 0a5", ifa.o_rsp_valid, ifa.o_rsp_rdata); else passes++;
    @(negedge clka);
    checks++; if ({ifa.o_rsp_valid, ifa.o_busy, ifa.o_rsp_rdata} !== {1'b0, 1'b0, 12'h000})
      $display("FAIL raw_drained: got %b %b %h, required 0 0 000", ifa.o_rsp_valid, ifa.o_busy, ifa.o_rsp_rdata); else passes++;
  endtask

  task test_credit_stall;
    int got, got_at_fire;
    logic fired;
    do_reset;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 8'(i); req_wdata = 12'h3A0 + 12'(i);
      @(negedge clka);
    end
    for (int i = 0; i < 4; i++) begin
      req_we = 1'b0; req_addr = 8'(i);
      #1;
      checks++; if (ifa.o_req_ready !== 1'b1)
        $display("FAIL stall_rd%0d_ready: got %b, required 1", i, ifa.o_req_ready); else passes++;
      @(negedge clka);
    end
    req_addr = 8'd4;
    #1;
    checks++; if (ifa.o_req_ready !== 1'b0)
      $display("FAIL stall_rd5_blocked: got %b, required 0", ifa.o_req_ready); else passes++;
    req_we = 1'b1; req_addr = 8'h40; req_wdata = 12'h777;
    #1;
    checks++; if (ifa.o_req_ready !== 1'b1)
      $display("FAIL stall_wr_ready: got %b, required 1", ifa.o_req_ready); else passes++;
    @(negedge clka);
    checks++; if ({ifa.o_en, ifa.o_we, ifa.o_addr} !== {1'b1, 1'b1, 8'h40})
      $display("FAIL stall_wr_issue: got %b%b %h, required 11 40", ifa.o_en, ifa.o_we, ifa.o_addr); else passes++;
    req_we = 1'b0; req_addr = 8'd4;
    repeat (3) @(negedge clka);
    #1;
    checks++; if ({ifa.o_req_ready, ifa.o_rsp_valid, ifa.o_rsp_rdata} !== {1'b0, 1'b1, 12'h3A0})
      $display("FAIL stall_full: got %b %b %h, required 0 1 3a0", ifa.o_req_ready, ifa.o_rsp_valid, ifa.o_rsp_rdata); else passes++;
    got = 0; got_at_fire = 0; fired = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (ifa.o_rsp_valid) begin
        exp_v = 12'h3A0 + 12'(got);
        checks++; if (ifa.o_rsp_rdata !== exp_v)
          $display("FAIL stall_order%0d: got %h, required %h", got, ifa.o_rsp_rdata, exp_v); else passes++;
        got++;
      end
      if (req_valid && ifa.o_req_ready && !fired) begin fired = 1'b1; got_at_fire = got; end
      @(negedge clka);
      if (fired) req_valid = 1'b0;
    end
    checks++; if (got !== 5)
      $display("FAIL stall_count: got %0d responses, required 5", got); else passes++;
    checks++; if (!fired || got_at_fire < 1)
      $display("FAIL stall_rd5_after_pop: fired %b after %0d responses, required 1 after >=1", fired, got_at_fire); else passes++;
  endtask

  task test_latency3_stream;
    int got, nxt, t_rsp [8];
    logic adv;
    do_reset;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20 + 8'(i); req_wdata = 12'h5C0 + 12'(i);
      @(negedge clka);
    end
    req_we = 1'b0; req_addr = 8'h20; req_valid = 1'b1;
    got = 0; nxt = 0; adv = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (ifb.o_rsp_valid) begin
        exp_v = 12'h5C0 + 12'(got);
        checks++; if (ifb.o_rsp_rdata !== exp_v)
          $display("FAIL lat3_order%0d: got %h, required %h", got, ifb.o_rsp_rdata, exp_v); else passes++;
        if (got < 8) t_rsp[got] = c;
        got++;
      end
      if (req_valid && ifb.o_req_ready) adv = 1'b1;
      @(negedge clka);
      if (adv) begin
        adv = 1'b0; nxt++;
        if (nxt == 8) req_valid = 1'b0;
        else req_addr = 8'h20 + 8'(nxt);
      end
    end
    checks++; if (got !== 8)
      $display("FAIL lat3_count: got %0d responses, required 8", got); else passes++;
    checks++; if (t_rsp[0] !== 5)
      $display("FAIL lat3_first: got cycle %0d, required 5", t_rsp[0]); else passes++;
    checks++; if (t_rsp[3] - t_rsp[0] !== 3)
      $display("FAIL lat3_no_gap: got span %0d, required 3", t_rsp[3] - t_rsp[0]); else passes++;
  endtask

  task test_reset_inflight;
    do_reset;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h20 + 8'(i);
      #1;
      checks++; if (ifb.o_req_ready !== 1'b1)
        $display("FAIL rstfl_rd%0d_ready: got %b, required 1", i, ifb.o_req_ready); else passes++;
      @(negedge clka);
    end
    req_valid = 1'b0;
    checks++; if (ifb.o_busy !== 1'b1)
      $display("FAIL rstfl_busy_before: got %b, required 1", ifb.o_busy); else passes++;
    rst = 1'b1;
    @(negedge clka);
    checks++; if ({ifb.o_busy, ifb.o_rsp_valid, ifb.o_req_ready} !== 3'b000)
      $display("FAIL rstfl_during: got %b, required 000", {ifb.o_busy, ifb.o_rsp_valid, ifb.o_req_ready}); else passes++;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clka);
      checks++; if ({ifb.o_rsp_valid, ifb.o_busy} !== 2'b00)
        $display("FAIL rstfl_none%0d: got %b, required 00", c, {ifb.o_rsp_valid, ifb.o_busy}); else passes++;
    end
  endtask

  task test_full_push_pop;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'(i);
      #1;
      checks++; if (ifa.o_req_ready !== 1'b1)
        $display("FAIL full_rd%0d_ready: got %b, required 1", i, ifa.o_req_ready); else passes++;
      @(negedge clka);
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clka);
    req_valid = 1'b1; req_addr = 8'd4;
    #1;
    checks++; if ({ifa.o_rsp_valid, ifa.o_rsp_rdata, ifa.o_req_ready} !== {1'b1, 12'h3A0, 1'b0})
      $display("FAIL full_state: got %b %h %b, required 1 3a0 0", ifa.o_rsp_valid, ifa.o_rsp_rdata, ifa.o_req_ready); else passes++;
    rsp_ready = 1'b1;
    @(negedge clka);
    rsp_ready = 1'b0;
    #1;
    checks++; if ({ifa.o_req_ready, ifa.o_rsp_rdata} !== {1'b1, 12'h3A1})
      $display("FAIL full_after_pop: got %b %h, required 1 3a1", ifa.o_req_ready, ifa.o_rsp_rdata); else passes++;
    @(negedge clka);
    req_valid = 1'b0;
    checks++; if ({ifa.o_en, ifa.o_we, ifa.o_addr} !== {1'b1, 1'b0, 8'd4})
      $display("FAIL full_rd5_issue: got %b%b %h, required 10 04", ifa.o_en, ifa.o_we, ifa.o_addr); else passes++;
    @(negedge clka);
    rsp_ready = 1'b1;
    @(negedge clka);
    rsp_ready = 1'b0;
    #1;
    checks++; if ({ifa.o_rsp_valid, ifa.o_rsp_rdata, ifa.o_req_ready} !== {1'b1, 12'h3A2, 1'b1})
      $display("FAIL full_push_pop: got %b %h %b, required 1 3a2 1", ifa.o_rsp_valid, ifa.o_rsp_rdata, ifa.o_req_ready); else passes++;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_v = 12'h3A2 + 12'(k);
      checks++; if ({ifa.o_rsp_valid, ifa.o_rsp_rdata} !== {1'b1, exp_v})
        $display("FAIL full_drain%0d: got %b %h, required 1 %h", k, ifa.o_rsp_valid, ifa.o_rsp_rdata, exp_v); else passes++;
      @(negedge clka);
      #1;
    end
    checks++; if ({ifa.o_rsp_valid, ifa.o_busy, ifa.o_rsp_rdata} !== {1'b0, 1'b0, 12'h000})
      $display("FAIL full_empty: got %b %b %h, required 0 0 000", ifa.o_rsp_valid, ifa.o_busy, ifa.o_rsp_rdata); else passes++;
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_credit_stall;
    test_latency3_stream;
    test_reset_inflight;
    test_full_push_pop;
    @(negedge clka);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
